// File: rtl/tx_byte_arbiter.sv
// Round-robin arbiter sharing one UART transmit byte channel between N_REQ level-held command
// sources: a byte is sent when it changes to a new nonzero value and re-sent on every refresh wrap.
module tx_byte_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned REFRESH_CYCLES = 50000000,
  parameter int unsigned BUSY_TIMEOUT   = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic               tx_busy,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic [N_REQ-1:0]   grant,
  output logic               sent_pulse
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned RW = $clog2(REFRESH_CYCLES);
  localparam int unsigned TW = $clog2(BUSY_TIMEOUT);

  localparam logic [IW-1:0] RR_INIT  = IW'(N_REQ - 1);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWaitHi, StWaitLo} state_e;

  state_e           state;
  logic [N_REQ-1:0] pending;
  logic [7:0]       last_sent [N_REQ];
  logic [IW-1:0]    rr_ptr;
  logic [RW-1:0]    ref_cnt;
  logic [TW-1:0]    wait_cnt;

  logic [7:0]       req [N_REQ];
  logic [N_REQ-1:0] eligible;
  logic             ref_wrap;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    cand;

  assign ref_wrap = (ref_cnt == REF_LAST);

  // A pending source whose byte has since dropped to zero is never granted, so 0x00 is never sent.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      req[i]      = req_data[8*i +: 8];
      eligible[i] = pending[i] && (req[i] != 8'h00);
    end
  end

  // Walk downwards so the candidate closest after rr_ptr is the last (winning) assignment.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned off = N_REQ; off >= 1; off--) begin
      cand = IW'((32'(rr_ptr) + off) % N_REQ);
      if (eligible[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      grant      <= '0;
      sent_pulse <= 1'b0;
      pending    <= '0;
      rr_ptr     <= RR_INIT;
      ref_cnt    <= '0;
      wait_cnt   <= '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        last_sent[i] <= 8'h00;
      end
    end else begin
      ref_cnt    <= ref_wrap ? '0 : ref_cnt + 1'b1;
      tx_start   <= 1'b0;
      sent_pulse <= 1'b0;

      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (req[i] == 8'h00) begin
          last_sent[i] <= 8'h00;
        end
        if (((req[i] != 8'h00) && (req[i] != last_sent[i])) ||
            (ref_wrap && (last_sent[i] != 8'h00))) begin
          pending[i] <= 1'b1;
        end else if (req[i] == 8'h00) begin
          pending[i] <= 1'b0;
        end
      end

      // Assignments below come later and override the per-source updates above.
      unique case (state)
        StIdle: begin
          if (pick_valid) begin
            tx_data             <= req[pick_idx];
            last_sent[pick_idx] <= req[pick_idx];
            pending[pick_idx]   <= 1'b0;
            grant               <= N_REQ'(1) << pick_idx;
            rr_ptr              <= pick_idx;
            state               <= StStart;
          end
        end
        StStart: begin
          tx_start <= 1'b1;
          wait_cnt <= '0;
          state    <= StWaitHi;
        end
        StWaitHi: begin
          if (tx_busy) begin
            state <= StWaitLo;
          end else if (wait_cnt == TO_LAST) begin
            state           <= StIdle;
            grant           <= '0;
            pending[rr_ptr] <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        StWaitLo: begin
          if (!tx_busy) begin
            state      <= StIdle;
            sent_pulse <= 1'b1;
            grant      <= '0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_byte_arbiter.sv
// Bench for tx_byte_arbiter: cycle table for the first send, directed corner sequences and a
// randomized run checked against a transaction-level model of the pending/round-robin rules.
module tb_tx_byte_arbiter;

  localparam int N   = 4;
  localparam int REF = 200;
  localparam int TO  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] req_data = '0;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [3:0]  grant;
  logic        sent_pulse;

  int checks = 0;
  int failures = 0;

  tx_byte_arbiter #(
    .N_REQ(N),
    .REFRESH_CYCLES(REF),
    .BUSY_TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_data(req_data),
    .tx_busy(tx_busy),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .grant(grant),
    .sent_pulse(sent_pulse)
  );

  always #5 clk = ~clk;

  // UART stand-in: latches on tx_start and stays busy for busy_len cycles.
  bit uart_en = 1'b1;
  int busy_len = 4;
  int busy_left = 0;
  always @(posedge clk) begin
    if (tx_start && uart_en) begin
      tx_busy   <= 1'b1;
      busy_left <= busy_len;
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else begin
      tx_busy   <= 1'b0;
      busy_left <= 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef logic [11:0] ent_t;
  ent_t log_q[$];
  ent_t exp_q[$];

  task automatic check_log(input string name);
    check({name, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < log_q.size()) check(name, log_q[i], exp_q[i]);
    end
  endtask

  // Reference model: state as of the previous clock edge, stepped once per cycle.
  logic [7:0] m_last [N];
  bit         m_pend [N];
  int         m_rr, m_edge, m_cur, gcyc;
  logic [7:0] m_byte;
  bit         saw_busy;
  logic [7:0] req_prev [N];
  bit         rst_prev = 1'b1;
  logic [3:0] g_prev = '0;

  task automatic model_step();
    int k;
    bit found;
    bit wrap;
    logic [7:0] old;
    if (rst_prev) begin
      for (int i = 0; i < N; i++) begin
        m_last[i] = 8'h00;
        m_pend[i] = 1'b0;
      end
      m_rr = N - 1;
      m_edge = 0;
      gcyc = 0;
      saw_busy = 1'b0;
    end else begin
      found = 1'b0;
      k = 0;
      for (int off = 1; off <= N; off++) begin
        if (!found && m_pend[(m_rr + off) % N] && req_prev[(m_rr + off) % N] != 8'h00) begin
          found = 1'b1;
          k = (m_rr + off) % N;
        end
      end
      if (g_prev == 4'b0000) begin
        if (found) begin
          check("arb_grant", grant, 32'(1 << k));
          check("arb_data", tx_data, req_prev[k]);
        end else begin
          check("idle_grant", grant, 0);
        end
      end
      wrap = (m_edge % REF) == REF - 1;
      m_edge++;
      for (int i = 0; i < N; i++) begin
        old = m_last[i];
        if (req_prev[i] == 8'h00) m_last[i] = 8'h00;
        if ((req_prev[i] != 8'h00 && req_prev[i] != old) || (wrap && old != 8'h00))
          m_pend[i] = 1'b1;
        else if (req_prev[i] == 8'h00)
          m_pend[i] = 1'b0;
      end
      if (g_prev == 4'b0000 && found) begin
        m_last[k] = req_prev[k];
        m_pend[k] = 1'b0;
        m_rr = k;
        m_cur = k;
        m_byte = req_prev[k];
        gcyc = 0;
        saw_busy = 1'b0;
      end else if (grant != 4'b0000) begin
        gcyc++;
      end
      if (g_prev != 4'b0000 && grant == 4'b0000) begin
        if (saw_busy) begin
          check("sent_pulse_end", sent_pulse, 1);
        end else begin
          check("timeout_no_pulse", sent_pulse, 0);
          check("timeout_cycles", gcyc, TO);
          m_pend[m_cur] = 1'b1;
        end
      end else begin
        check("sent_pulse_quiet", sent_pulse, 0);
      end
      check("tx_start", tx_start, (grant != 4'b0000) && (gcyc == 1));
      if (grant != 4'b0000) check("tx_data_hold", tx_data, m_byte);
      if (grant != 4'b0000 && tx_busy) saw_busy = 1'b1;
      if (tx_start) log_q.push_back({grant, tx_data});
    end
    rst_prev = rst;
    g_prev = grant;
    for (int i = 0; i < N; i++) req_prev[i] = req_data[8*i +: 8];
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(1);
    rst = 1'b1;
    req_data = '0;
    tick(1);
    rst = 1'b0;
    log_q.delete();
  endtask

  task automatic wait_start(input string name, input int bound);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      tick(1);
      hit = tx_start;
    end
    check(name, hit, 1);
  endtask

  typedef struct {
    logic       rst;
    logic [7:0] req0;
    logic       st;
    logic [3:0] gr;
    logic [7:0] dat;
    logic       sp;
  } vec_t;

  vec_t tbl [12];
  int   n;
  bit   hit;
  logic [7:0] v;
  int   src;

  initial begin
    tbl[0]  = '{1'b1, 8'h00, 1'b0, 4'b0000, 8'h00, 1'b0};
    tbl[1]  = '{1'b0, 8'h0B, 1'b0, 4'b0000, 8'h00, 1'b0};
    tbl[2]  = '{1'b0, 8'h0B, 1'b0, 4'b0001, 8'h0B, 1'b0};
    tbl[3]  = '{1'b0, 8'h0B, 1'b1, 4'b0001, 8'h0B, 1'b0};
    for (int i = 4; i <= 8; i++) tbl[i] = '{1'b0, 8'h0B, 1'b0, 4'b0001, 8'h0B, 1'b0};
    tbl[9]  = '{1'b0, 8'h0B, 1'b0, 4'b0000, 8'h0B, 1'b1};
    tbl[10] = '{1'b0, 8'h0B, 1'b0, 4'b0000, 8'h0B, 1'b0};
    tbl[11] = '{1'b0, 8'h0B, 1'b0, 4'b0000, 8'h0B, 1'b0};

    // First send, cycle by cycle, with a 4-cycle UART frame.
    busy_len = 4;
    tick(1);
    for (int j = 0; j < 12; j++) begin
      rst = tbl[j].rst;
      req_data[7:0] = tbl[j].req0;
      tick(1);
      check($sformatf("tbl%0d_tx_start", j), tx_start, tbl[j].st);
      check($sformatf("tbl%0d_grant", j), grant, tbl[j].gr);
      check($sformatf("tbl%0d_tx_data", j), tx_data, tbl[j].dat);
      check($sformatf("tbl%0d_sent_pulse", j), sent_pulse, tbl[j].sp);
    end
    tick(100);
    check("held_no_resend", log_q.size(), 1);

    // Three simultaneous sources, then source 0 changes while source 1 is in flight.
    busy_len = 10;
    do_reset();
    req_data = {8'h00, 8'h27, 8'h13, 8'h0B};
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick(1);
      hit = (grant == 4'b0010);
    end
    check("rr_src1_in_flight", hit, 1);
    req_data[7:0] = 8'h0F;
    tick(120);
    exp_q = '{{4'b0001, 8'h0B}, {4'b0010, 8'h13}, {4'b0100, 8'h27}, {4'b0001, 8'h0F}};
    check_log("rr_order");

    // Keep-alive refresh of live bytes; a source dropped to zero leaves the rotation.
    do_reset();
    req_data = {8'h45, 8'h00, 8'h13, 8'h00};
    tick(460);
    req_data[31:24] = 8'h00;
    tick(400);
    exp_q = '{{4'b0010, 8'h13}, {4'b1000, 8'h45}, {4'b0010, 8'h13}, {4'b1000, 8'h45},
              {4'b0010, 8'h13}, {4'b1000, 8'h45}, {4'b0010, 8'h13}, {4'b0010, 8'h13}};
    check_log("refresh");

    // UART never goes busy: timeout, no sent_pulse, same byte retried.
    uart_en = 1'b0;
    do_reset();
    req_data[7:0] = 8'h0B;
    wait_start("to_first_start", 20);
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick(1);
      n++;
      hit = (grant == 4'b0000);
    end
    check("to_grant_drop_cycles", n, TO);
    check("to_no_sent_pulse", sent_pulse, 0);
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick(1);
      n++;
      hit = tx_start;
    end
    check("to_retry_latency", n, 2);
    check("to_retry_data", tx_data, 8'h0B);
    uart_en = 1'b1;

    // Reset while waiting for busy to fall.
    do_reset();
    req_data[7:0] = 8'h0B;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      tick(1);
      hit = tx_busy && (grant != 4'b0000);
    end
    check("rst_reached_busy", hit, 1);
    tick(3);
    rst = 1'b1;
    tick(1);
    check("rst_tx_start", tx_start, 0);
    check("rst_grant", grant, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_sent_pulse", sent_pulse, 0);
    rst = 1'b0;
    wait_start("rst_resend", 20);
    check("rst_resend_data", tx_data, 8'h0B);
    check("rst_resend_grant", grant, 4'b0001);
    tick(20);

    // Refresh wrap coincides with a change on source 2.
    do_reset();
    req_data[23:16] = 8'h27;
    tick(199);
    req_data[23:16] = 8'h2B;
    tick(100);
    exp_q = '{{4'b0100, 8'h27}, {4'b0100, 8'h2B}};
    check_log("wrap_and_change");

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick(1);
      busy_len = $urandom_range(1, 12);
      uart_en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 15) == 0) begin
        src = $urandom_range(0, 3);
        case ($urandom_range(0, 4))
          0: v = 8'h00;
          1: v = 8'h0B;
          2: v = 8'h13;
          3: v = 8'h27;
          default: v = 8'($urandom_range(1, 255));
        endcase
        req_data[8*src +: 8] = v;
      end
    end
    uart_en = 1'b1;
    tick(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
